read_counter_sequencer: RTL

Synchronous controller that sequences the CDU read counter. It generates the repeating four-phase timing (FAZ2HI_n, FAZ3HI), accumulates up and down step requests from the error-detect logic, and issues at most one counter step per phase cycle. It also arbitrates zeroing requests against stepping. It sits between the resolver/error-detect logic and the read counter.

---
 rtl/read_counter_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/read_counter_sequencer.sv
// Read counter sequencer: free-running four-phase timer, signed step accumulator and a step/zero FSM.
// Optional shadow model of the read counter is enabled by defining READ_COUNTER_SHADOW_EN.
module read_counter_sequencer #(
    parameter int PHASE_LEN = 4,
    parameter int PEND_W    = 6,
    parameter int MAX_PEND  = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_req,
    input  logic                     dn_req,
    input  logic                     zero_req,
    output logic                     zero_ack,
    output logic                     faz2hi_n,
    output logic                     faz3hi,
    output logic                     up_lvl_n,
    output logic                     dn_lvl_n,
    output logic                     pihi_n,
    output logic                     cduz,
    output logic                     step_done,
    output logic signed [PEND_W-1:0] pend,
    output logic                     pend_ovf,
    output logic                     busy
`ifdef READ_COUNTER_SHADOW_EN
    ,
    output logic [15:0]              shadow_count
`endif
);

    localparam int CNT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PHASE_LEN - 1);

    typedef enum logic [1:0] {IDLE, STEP_UP, STEP_DN, ZERO} state_t;

    state_t                   state, state_d;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic [1:0]               phase, phase_d;
    logic                     cycle_end;
    logic signed [PEND_W-1:0] pend_d;
    logic                     pend_ovf_d;
    int                       step_adj;
    int                       delta;
    int                       raw;

    always_comb begin
        cnt_d     = cnt + 1'b1;
        phase_d   = phase;
        cycle_end = (phase == 2'd3) && (cnt == CNT_MAX);
        if (cnt == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = phase + 2'd1;
        end
    end

    // The decision taken on the last clock of phase 3 becomes the state for the whole next cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        state_d    = state;
        step_adj   = 0;
        pend_d     = pend;
        pend_ovf_d = pend_ovf;
        delta      = int'(up_req) - int'(dn_req);
        raw        = 0;
        if (cycle_end) begin
            if (zero_req) begin
                state_d = ZERO;
            end else if (pend > 0) begin
                state_d  = STEP_UP;
                step_adj = -1;
            end else if (pend < 0) begin
                state_d  = STEP_DN;
                step_adj = 1;
            end else begin
                state_d = IDLE;
            end
        end
        if ((cycle_end && state_d == ZERO) || state == ZERO) begin
            pend_d     = '0;
            pend_ovf_d = 1'b0;
        end else begin
            raw = int'(pend) + step_adj + delta;
            if (raw > MAX_PEND) begin
                pend_d     = PEND_W'(MAX_PEND);
                pend_ovf_d = 1'b1;
            end else if (raw < -MAX_PEND) begin
                pend_d     = PEND_W'(-MAX_PEND);
                pend_ovf_d = 1'b1;
            end else begin
                pend_d = PEND_W'(raw);
            end
        end
    end

    always_comb begin
        up_lvl_n  = 1'b1;
        dn_lvl_n  = 1'b1;
        pihi_n    = 1'b1;
        cduz      = 1'b0;
        step_done = 1'b0;
        zero_ack  = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            STEP_UP: begin
                up_lvl_n  = 1'b0;
                pihi_n    = !(phase == 2'd1 || phase == 2'd2);
                step_done = cycle_end;
            end
            STEP_DN: begin
                dn_lvl_n  = 1'b0;
                pihi_n    = !(phase == 2'd1 || phase == 2'd2);
                step_done = cycle_end;
            end
            ZERO: begin
                cduz     = 1'b1;
                zero_ack = cycle_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt      <= '0;
            phase    <= 2'd0;
            state    <= IDLE;
            pend     <= '0;
            pend_ovf <= 1'b0;
            faz2hi_n <= 1'b1;
            faz3hi   <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            phase    <= phase_d;
            state    <= state_d;
            pend     <= pend_d;
            pend_ovf <= pend_ovf_d;
            faz2hi_n <= (phase_d != 2'd2);
            faz3hi   <= (phase_d == 2'd3);
        end
    end

`ifdef READ_COUNTER_SHADOW_EN
    always_ff @(posedge clk) begin
        if (rst || state == ZERO) begin
            shadow_count <= '0;
        end else if (step_done) begin
            shadow_count <= (state == STEP_UP) ? shadow_count + 16'd1 : shadow_count - 16'd1;
        end
    end
`endif

endmodule
